hist2d_readout: RTL and testbench

- Reader side of the 2D IQ histogram memory that hist2d_store_bin fills.
- On a start pulse, scans every bin of the active i_bin_num x q_bin_num grid in raster order.
- Reads each bin count from the histogram BRAM port and streams (i, q, count) over a valid/ready interface toward the host uplink/display.
- Optionally zeroes each bin after its count has been accepted, so the next acquisition starts from a clean histogram.

---
 rtl/hist2d_readout.sv | 128 ++++++++++++
 tb/tb_hist2d_readout.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist2d_readout.sv
// Raster-order readout of the 2D IQ histogram memory: streams (i, q, count) words
// over valid/ready and can zero each bin once its word has been accepted.
module hist2d_readout #(
   parameter int COORD_W = 8,
   parameter int COUNT_W = 16,
   parameter int ADDR_W  = 16
) (
   input  logic               clk100,
   input  logic               rst,
   input  logic               start,
   input  logic               clear_after_read,
   input  logic [COORD_W-1:0] i_bin_num,
   input  logic [COORD_W-1:0] q_bin_num,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [COUNT_W-1:0] rd_data,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COUNT_W-1:0] wr_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COORD_W-1:0] out_i,
   output logic [COORD_W-1:0] out_q,
   output logic [COUNT_W-1:0] out_count,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_READ, ST_WAIT, ST_PRESENT, ST_FINISH
   } state_t;

   state_t             state;
   logic [COORD_W-1:0] i_num, q_num;
   logic [COORD_W-1:0] i_cnt, q_cnt;
   logic [COORD_W-1:0] i_next, q_next;
   logic               clear_lat;
   logic               handshake;

   assign handshake = (state == ST_PRESENT) && out_valid && out_ready;

   // Raster advance: i wraps at i_num-1 and carries into q.
   always_comb begin
      i_next = i_cnt + COORD_W'(1);
      q_next = q_cnt;
      if (i_cnt == i_num - COORD_W'(1)) begin
         i_next = '0;
         q_next = q_cnt + COORD_W'(1);
      end
   end

   // The clear write must land on the handshake cycle itself, so it is decoded
   // directly rather than registered; out_q/out_i hold the current bin there.
   assign wr_en   = handshake && clear_lat;
   assign wr_addr = {out_q, out_i};
   assign wr_data = '0;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk100) begin
      if (rst) begin
         state     <= ST_IDLE;
         i_num     <= '0;
         q_num     <= '0;
         i_cnt     <= '0;
         q_cnt     <= '0;
         clear_lat <= 1'b0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  i_num     <= i_bin_num;
                  q_num     <= q_bin_num;
                  clear_lat <= clear_after_read;
                  i_cnt     <= '0;
                  q_cnt     <= '0;
                  if (i_bin_num == '0 || q_bin_num == '0) begin
                     state <= ST_FINISH;
                     done  <= 1'b1;
                  end else begin
                     state   <= ST_READ;
                     busy    <= 1'b1;
                     rd_addr <= '0;
                  end
               end
            end
            ST_READ: state <= ST_WAIT;
            ST_WAIT: begin
               out_count <= rd_data;
               out_i     <= i_cnt;
               out_q     <= q_cnt;
               out_valid <= 1'b1;
               out_last  <= (i_cnt == i_num - COORD_W'(1)) &&
                            (q_cnt == q_num - COORD_W'(1));
               state     <= ST_PRESENT;
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  i_cnt     <= i_next;
                  q_cnt     <= q_next;
                  if (out_last) begin
                     state <= ST_FINISH;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state   <= ST_READ;
                     rd_addr <= {q_next, i_next};
                  end
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hist2d_readout.sv
// Randomized scoreboard bench for hist2d_readout: a behavioural BRAM, a raster-order
// reference model feeding word/write queues, and a negedge monitor that checks them.
module tb_hist2d_readout;

   logic        clk100 = 1'b0;
   logic        rst, start, clear_after_read;
   logic [7:0]  i_bin_num, q_bin_num;
   logic [15:0] rd_addr, rd_data, wr_addr, wr_data;
   logic        wr_en, out_valid, out_ready, out_last, busy, done;
   logic [7:0]  out_i, out_q;
   logic [15:0] out_count;

   hist2d_readout #(.COORD_W(8), .COUNT_W(16), .ADDR_W(16)) dut (
      .clk100(clk100), .rst(rst), .start(start), .clear_after_read(clear_after_read),
      .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_i(out_i), .out_q(out_q), .out_count(out_count),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk100 = ~clk100;

   typedef struct packed {
      logic [7:0]  i;
      logic [7:0]  q;
      logic [15:0] count;
      logic        last;
   } word_t;

   word_t       exp_q[$];
   logic [15:0] exp_wr[$];
   logic [15:0] bram    [0:65535];
   logic [15:0] ref_mem [0:65535];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          rdy_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous-read memory: data for rd_addr appears one cycle later.
   always @(posedge clk100) begin
      if (wr_en) bram[wr_addr] <= wr_data;
      rd_data <= bram[rd_addr];
   end

   // Downstream ready: always 1, the 1,0,0,1 pattern, or random.
   initial begin
      int ph = 0;
      logic [3:0] pat;
      pat = 4'b1001;
      out_ready = 1'b1;
      forever begin
         @(posedge clk100);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[ph % 4];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
      end
   end

   // Monitor: pops the scoreboard on each accepted word and each clear write.
   logic        hold = 1'b0;
   logic [15:0] h_iq, h_count;
   logic        h_last;
   always @(negedge clk100) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_iq", 32'({out_i, out_q}), 32'(h_iq));
            check("hold_count", 32'(out_count), 32'(h_count));
            check("hold_last", 32'(out_last), 32'(h_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", 32'(out_count), 32'hdead_beef);
            else begin
               word_t e;
               e = exp_q.pop_front();
               check("word_i", 32'(out_i), 32'(e.i));
               check("word_q", 32'(out_q), 32'(e.q));
               check("word_count", 32'(out_count), 32'(e.count));
               check("word_last", 32'(out_last), 32'(e.last));
            end
         end
         if (wr_en) begin
            check("wr_on_handshake", 32'(out_valid && out_ready), 32'd1);
            check("wr_data", 32'(wr_data), 32'd0);
            if (exp_wr.size() == 0) check("unexpected_wr", 32'(wr_addr), 32'hdead_beef);
            else check("wr_addr", 32'(wr_addr), 32'(exp_wr.pop_front()));
         end
         hold    = out_valid && !out_ready;
         h_iq    = {out_i, out_q};
         h_count = out_count;
         h_last  = out_last;
      end
   end

   task automatic wait_cycle();
      @(posedge clk100);
      #1;
   endtask

   task automatic preload(input int inum, input int qnum, input bit addr_plus_one);
      for (int q = 0; q < qnum; q++)
         for (int i = 0; i < inum; i++) begin
            logic [15:0] a, v;
            a = {q[7:0], i[7:0]};
            v = addr_plus_one ? a + 16'd1 : 16'($urandom);
            bram[a] = v;
            ref_mem[a] = v;
         end
   endtask

   // Reference model: raster order q-outer / i-inner, last on the final bin.
   task automatic expect_scan(input int inum, input int qnum, input bit clr);
      for (int q = 0; q < qnum; q++)
         for (int i = 0; i < inum; i++) begin
            word_t w;
            w.i = i[7:0];
            w.q = q[7:0];
            w.count = ref_mem[{q[7:0], i[7:0]}];
            w.last = (i == inum - 1) && (q == qnum - 1);
            exp_q.push_back(w);
            if (clr) begin
               exp_wr.push_back({q[7:0], i[7:0]});
               ref_mem[{q[7:0], i[7:0]}] = 16'd0;
            end
         end
   endtask

   task automatic run_scan(input int inum, input int qnum, input bit clr,
                           input int mode, input bit inject);
      int n, cycles, bound;
      n = inum * qnum;
      bound = 20 * n + 10;
      rdy_mode = mode;
      expect_scan(inum, qnum, clr);
      start = 1'b1;
      i_bin_num = inum[7:0];
      q_bin_num = qnum[7:0];
      clear_after_read = clr;
      wait_cycle();
      start = 1'b0;
      i_bin_num = 8'($urandom);
      q_bin_num = 8'($urandom);
      clear_after_read = 1'($urandom_range(0, 1));
      cycles = 1;
      check("busy_after_start", 32'(busy), (n > 0) ? 32'd1 : 32'd0);
      while (!done && cycles < bound) begin
         if (inject && cycles == 4) begin
            start = 1'b1;
            i_bin_num = 8'd5;
            q_bin_num = 8'd5;
            clear_after_read = 1'b1;
         end else begin
            start = 1'b0;
         end
         wait_cycle();
         cycles++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 32'd1);
      if (n == 0) check("zero_done_within_2", 32'(cycles <= 2), 32'd1);
      else if (mode == 0) check("scan_latency", 32'(cycles), 32'(3 * n + 1));
      check("busy_at_done", 32'(busy), 32'd0);
      wait_cycle();
      check("done_one_cycle", 32'(done), 32'd0);
      check("words_left", 32'(exp_q.size()), 32'd0);
      check("writes_left", 32'(exp_wr.size()), 32'd0);
   endtask

   initial begin
      int d0, guard;
      for (int a = 0; a < 65536; a++) begin
         bram[a] = 16'd0;
         ref_mem[a] = 16'd0;
      end
      rst = 1'b1;
      start = 1'b1;
      clear_after_read = 1'b1;
      i_bin_num = 8'd2;
      q_bin_num = 8'd2;
      wait_cycle();
      wait_cycle();
      check("rst_outputs", 32'({busy, done, out_valid, out_last, wr_en}), 32'd0);
      check("rst_addrs", 32'({rd_addr, wr_addr}), 32'd0);
      check("rst_out_iq", 32'({out_i, out_q, out_count}), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      wait_cycle();
      wait_cycle();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done_cnt", 32'(done_cnt), 32'd0);

      // Basic scan, then the same with 1,0,0,1 backpressure.
      preload(3, 2, 1'b1);
      run_scan(3, 2, 1'b0, 0, 1'b0);
      run_scan(3, 2, 1'b0, 1, 1'b0);

      // Clear after read, then a rescan must return zeros.
      preload(2, 2, 1'b0);
      run_scan(2, 2, 1'b1, 0, 1'b0);
      run_scan(2, 2, 1'b0, 2, 1'b0);

      // Zero-size grids and a start pulse while busy.
      d0 = done_cnt;
      run_scan(0, 3, 1'b1, 0, 1'b0);
      run_scan(4, 0, 1'b1, 0, 1'b0);
      check("zero_done_count", 32'(done_cnt - d0), 32'd2);
      preload(3, 2, 1'b0);
      run_scan(3, 2, 1'b0, 0, 1'b1);

      // Reset during PRESENT of the second word.
      preload(3, 2, 1'b0);
      rdy_mode = 0;
      expect_scan(3, 2, 1'b0);
      start = 1'b1;
      i_bin_num = 8'd3;
      q_bin_num = 8'd2;
      clear_after_read = 1'b0;
      wait_cycle();
      start = 1'b0;
      guard = 0;
      while (!(out_valid && out_i == 8'd1 && out_q == 8'd0) && guard < 50) begin
         wait_cycle();
         guard++;
      end
      check("reached_word2", 32'(guard < 50), 32'd1);
      rst = 1'b1;
      d0 = done_cnt;
      wait_cycle();
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      exp_wr.delete();
      repeat (6) wait_cycle();
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      run_scan(3, 2, 1'b0, 0, 1'b0);

      // Widest i range and randomized scans.
      preload(255, 2, 1'b0);
      run_scan(255, 2, 1'b0, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         int ni, nq;
         ni = $urandom_range(1, 5);
         nq = $urandom_range(1, 4);
         preload(ni, nq, 1'b0);
         run_scan(ni, nq, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
